// File: rtl/utils_pkg.sv
// -----------------------------------------------------------------------------
// utils_pkg
// Shared types and small helpers for the load/store datapath.
//   mem_size_e  : access size encoding (BYTE, HALF, WORD, DOUBLE)
//   strb_t      : one enable bit per byte lane of a 64-bit beat
//   size_bytes  : access size -> number of bytes (1, 2, 4 or 8)
//   zext_data   : keep only the low bytes of an access, upper bits cleared
//   sext_data   : same, but replicate the sign bit of the access upward
// -----------------------------------------------------------------------------
package utils_pkg;

  typedef enum logic [1:0] {
    BYTE   = 2'd0,
    HALF   = 2'd1,
    WORD   = 2'd2,
    DOUBLE = 2'd3
  } mem_size_e;

  typedef logic [7:0] strb_t;

  localparam int unsigned BEAT_BYTES = 8;

  function automatic logic [3:0] size_bytes(input mem_size_e size);
    case (size)
      BYTE:    return 4'd1;
      HALF:    return 4'd2;
      WORD:    return 4'd4;
      default: return 4'd8;
    endcase
  endfunction

  function automatic logic [63:0] zext_data(input logic [63:0] data, input mem_size_e size);
    case (size)
      BYTE:    return {56'd0, data[7:0]};
      HALF:    return {48'd0, data[15:0]};
      WORD:    return {32'd0, data[31:0]};
      default: return data;
    endcase
  endfunction

  function automatic logic [63:0] sext_data(input logic [63:0] data, input mem_size_e size);
    case (size)
      BYTE:    return {{56{data[7]}}, data[7:0]};
      HALF:    return {{48{data[15]}}, data[15:0]};
      WORD:    return {{32{data[31]}}, data[31:0]};
      default: return data;
    endcase
  endfunction

endpackage

// File: rtl/store_align.sv
// -----------------------------------------------------------------------------
// store_align
// Combinational lane alignment for a store. The data is trimmed to the access
// size and placed at its byte offset inside a 16-byte window (two beats); the
// strobe marks the same bytes.
//   i_off    : address bits [2:0] (byte offset inside the first beat)
//   i_data   : store data, LSB-justified
//   i_size   : access size
//   o_wdata  : 128-bit lane-aligned data, [63:0] first beat, [127:64] second
//   o_strb   : 16-bit byte enables matching o_wdata
//   o_cross  : access spills into the second beat (off + n > 8)
// -----------------------------------------------------------------------------
module store_align
  import utils_pkg::*;
(
  input  logic [2:0]   i_off,
  input  logic [63:0]  i_data,
  input  mem_size_e    i_size,
  output logic [127:0] o_wdata,
  output logic [15:0]  o_strb,
  output logic         o_cross
);

  logic [3:0]  w_nbytes;
  logic [4:0]  w_end;
  logic [63:0] w_masked;

  assign w_nbytes = size_bytes(i_size);
  // One past the last byte touched, measured from the first beat's lane 0.
  assign w_end    = {2'b00, i_off} + {1'b0, w_nbytes};
  assign w_masked = zext_data(i_data, i_size);

  assign o_wdata  = {64'd0, w_masked} << {i_off, 3'b000};
  assign o_cross  = (w_end > 5'd8);

  genvar gi;
  generate
    for (gi = 0; gi < 16; gi++) begin : g_strb
      assign o_strb[gi] = (5'(gi) >= {2'b00, i_off}) && (5'(gi) < w_end);
    end
  endgenerate

endmodule

// File: rtl/store_unit.sv
// -----------------------------------------------------------------------------
// store_unit
// Turns a sized store request into one or two 8-byte-aligned write beats.
// Configuration macro: STORE_MISALIGNED_SPLIT_EN
//   defined   : a store crossing an 8-byte boundary is split into two beats
//   undefined : a crossing store is dropped; done and misaligned_err pulse
//               together and no beat is issued
// Ports:
//   clk, rst        : clock, synchronous active-high reset
//   req_valid/ready : request handshake (ready only while idle)
//   req_addr/data/size : byte address, LSB-justified data, size code
//   mem_valid/ready : write beat handshake
//   mem_addr/wdata/wstrb : aligned beat address, lane data, byte enables
//   done            : one-cycle completion pulse
//   misaligned_err  : one-cycle pulse with done for a dropped crossing store
// -----------------------------------------------------------------------------
module store_unit
  import utils_pkg::*;
#(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_data,
  input  logic [1:0]            req_size,
  output logic                  mem_valid,
  input  logic                  mem_ready,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output strb_t                 mem_wstrb,
  output logic                  done,
  output logic                  misaligned_err
);

  typedef enum logic [1:0] {IDLE, BEAT0, BEAT1, DONE} state_e;

  state_e                r_state, w_state_next;
  logic                  r_mem_valid, w_mem_valid_next;
  logic [ADDR_WIDTH-1:0] r_mem_addr, w_mem_addr_next;
  logic [DATA_WIDTH-1:0] r_mem_wdata, w_mem_wdata_next;
  strb_t                 r_mem_wstrb, w_mem_wstrb_next;
  logic                  r_done, w_done_next;

  logic [127:0]          w_shift_data;
  logic [15:0]           w_shift_strb;
  logic                  w_cross;
  logic [ADDR_WIDTH-1:0] w_beat_addr;

  store_align u_align (
    .i_off   (req_addr[2:0]),
    .i_data  (req_data),
    .i_size  (mem_size_e'(req_size)),
    .o_wdata (w_shift_data),
    .o_strb  (w_shift_strb),
    .o_cross (w_cross)
  );

  assign w_beat_addr = {req_addr[ADDR_WIDTH-1:3], 3'b000};

`ifdef STORE_MISALIGNED_SPLIT_EN
  // Second-beat payload captured at acceptance so the request bus is free.
  logic [DATA_WIDTH-1:0] r_hi_wdata, w_hi_wdata_next;
  strb_t                 r_hi_wstrb, w_hi_wstrb_next;
  logic                  r_cross, w_cross_next;
`else
  logic r_err, w_err_next;
  // Upper half of the alignment window has no consumer without splitting.
  logic w_unused_hi;
  assign w_unused_hi = ^{w_shift_data[127:64], w_shift_strb[15:8]};
`endif

  always_comb begin
    w_state_next     = r_state;
    w_mem_valid_next = r_mem_valid;
    w_mem_addr_next  = r_mem_addr;
    w_mem_wdata_next = r_mem_wdata;
    w_mem_wstrb_next = r_mem_wstrb;
    w_done_next      = 1'b0;
`ifdef STORE_MISALIGNED_SPLIT_EN
    w_hi_wdata_next  = r_hi_wdata;
    w_hi_wstrb_next  = r_hi_wstrb;
    w_cross_next     = r_cross;
`else
    w_err_next       = 1'b0;
`endif
    case (r_state)
      IDLE: begin
        if (req_valid) begin
`ifndef STORE_MISALIGNED_SPLIT_EN
          if (w_cross) begin
            // Crossing store cannot be issued as one beat: report and drop.
            w_state_next = DONE;
            w_done_next  = 1'b1;
            w_err_next   = 1'b1;
          end else
`endif
          begin
            w_state_next     = BEAT0;
            w_mem_valid_next = 1'b1;
            w_mem_addr_next  = w_beat_addr;
            w_mem_wdata_next = w_shift_data[63:0];
            w_mem_wstrb_next = w_shift_strb[7:0];
`ifdef STORE_MISALIGNED_SPLIT_EN
            w_hi_wdata_next  = w_shift_data[127:64];
            w_hi_wstrb_next  = w_shift_strb[15:8];
            w_cross_next     = w_cross;
`endif
          end
        end
      end
      BEAT0: begin
        if (mem_ready) begin
`ifdef STORE_MISALIGNED_SPLIT_EN
          if (r_cross) begin
            // Address increment wraps naturally at the top of the space.
            w_state_next     = BEAT1;
            w_mem_addr_next  = r_mem_addr + ADDR_WIDTH'(8);
            w_mem_wdata_next = r_hi_wdata;
            w_mem_wstrb_next = r_hi_wstrb;
          end else
`endif
          begin
            w_state_next     = DONE;
            w_mem_valid_next = 1'b0;
            w_done_next      = 1'b1;
          end
        end
      end
      BEAT1: begin
`ifdef STORE_MISALIGNED_SPLIT_EN
        if (mem_ready) begin
          w_state_next     = DONE;
          w_mem_valid_next = 1'b0;
          w_done_next      = 1'b1;
        end
`else
        // Unreachable without splitting; recover to idle.
        w_state_next     = IDLE;
        w_mem_valid_next = 1'b0;
`endif
      end
      DONE: begin
        w_state_next = IDLE;
      end
      default: begin
        w_state_next     = IDLE;
        w_mem_valid_next = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_mem_valid <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_mem_wstrb <= '0;
      r_done      <= 1'b0;
`ifdef STORE_MISALIGNED_SPLIT_EN
      r_hi_wdata  <= '0;
      r_hi_wstrb  <= '0;
      r_cross     <= 1'b0;
`else
      r_err       <= 1'b0;
`endif
    end else begin
      r_state     <= w_state_next;
      r_mem_valid <= w_mem_valid_next;
      r_mem_addr  <= w_mem_addr_next;
      r_mem_wdata <= w_mem_wdata_next;
      r_mem_wstrb <= w_mem_wstrb_next;
      r_done      <= w_done_next;
`ifdef STORE_MISALIGNED_SPLIT_EN
      r_hi_wdata  <= w_hi_wdata_next;
      r_hi_wstrb  <= w_hi_wstrb_next;
      r_cross     <= w_cross_next;
`else
      r_err       <= w_err_next;
`endif
    end
  end

  assign req_ready = (r_state == IDLE);
  assign mem_valid = r_mem_valid;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign mem_wstrb = r_mem_wstrb;
  assign done      = r_done;
`ifdef STORE_MISALIGNED_SPLIT_EN
  assign misaligned_err = 1'b0;
`else
  assign misaligned_err = r_err;
`endif

endmodule

// File: tb/tb_store_unit.sv
// -----------------------------------------------------------------------------
// tb_store_unit
// Self-checking bench for store_unit. A byte-placement model builds the list
// of beats each store must produce; a negedge monitor compares every beat,
// done and misaligned_err pulse against it. Directed cases pin the model with
// literal values; a randomized phase covers sizes, offsets and backpressure.
// Honours STORE_MISALIGNED_SPLIT_EN the same way as the design.
// -----------------------------------------------------------------------------
module tb_store_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [63:0] req_addr;
  logic [63:0] req_data;
  logic [1:0]  req_size;
  logic        mem_valid;
  logic        mem_ready = 1'b1;
  logic [63:0] mem_addr;
  logic [63:0] mem_wdata;
  logic [7:0]  mem_wstrb;
  logic        done;
  logic        misaligned_err;

  always #5 clk = ~clk;

  store_unit #(.DATA_WIDTH(64), .ADDR_WIDTH(64)) dut (
    .clk            (clk),
    .rst            (rst),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_addr       (req_addr),
    .req_data       (req_data),
    .req_size       (req_size),
    .mem_valid      (mem_valid),
    .mem_ready      (mem_ready),
    .mem_addr       (mem_addr),
    .mem_wdata      (mem_wdata),
    .mem_wstrb      (mem_wstrb),
    .done           (done),
    .misaligned_err (misaligned_err)
  );

  typedef struct {
    logic [63:0] addr;
    logic [63:0] data;
    logic [7:0]  strb;
  } beat_t;

  beat_t exp_q[$];
  beat_t m_beats[$];
  bit    m_err;

  int compared = 0;
  int mismatched = 0;
  int cyc = 0;
  bit outstanding = 0;
  bit exp_err = 0;
  bit ready_check = 0;
  int done_cyc = 0;
  int acc_n = 0;
  int beats_seen = 0;
  int exp_nbeats = 0;
  int stall_cnt = 0;
  bit rand_ready = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(string name, logic [127:0] act, logic [127:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  // Place each byte of the access at (offset + i) in a 16-byte window, then
  // cut the window into 8-byte beats.
  function automatic void model(input logic [63:0] a, input logic [63:0] d, input logic [1:0] s);
    logic [127:0] lanes;
    logic [15:0]  en;
    int           off;
    int           n;
    beat_t        b;
    lanes = '0;
    en    = '0;
    off   = int'(a[2:0]);
    n     = 1 << s;
    for (int i = 0; i < n; i++) begin
      lanes[(off + i) * 8 +: 8] = d[i * 8 +: 8];
      en[off + i] = 1'b1;
    end
    m_beats.delete();
    m_err  = 1'b0;
    b.addr = {a[63:3], 3'b000};
    b.data = lanes[63:0];
    b.strb = en[7:0];
    if (off + n <= 8) begin
      m_beats.push_back(b);
    end else begin
`ifdef STORE_MISALIGNED_SPLIT_EN
      m_beats.push_back(b);
      b.addr = b.addr + 64'd8;
      b.data = lanes[127:64];
      b.strb = en[15:8];
      m_beats.push_back(b);
`else
      m_err = 1'b1;
`endif
    end
  endfunction

  // Memory-side ready: explicit stall count (consumed only while a beat is
  // presented), otherwise always-ready or random.
  always @(posedge clk) begin
    #2;
    if (stall_cnt > 0) begin
      mem_ready = 1'b0;
      if (mem_valid) stall_cnt--;
    end else begin
      mem_ready = rand_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
    end
  end

  // Compare process: every cycle out of reset.
  always @(negedge clk) begin
    if (!rst) begin
      if (ready_check) begin
        chk("ready_after_done", req_ready, 1);
        ready_check = 0;
      end
      if (mem_valid) begin
        chk("wstrb_nonzero", (mem_wstrb != 8'h00), 1);
        if (exp_q.size() == 0) begin
          chk("unexpected_beat", mem_valid, 0);
        end else begin
          chk("beat_addr", mem_addr, exp_q[0].addr);
          chk("beat_wdata", mem_wdata, exp_q[0].data);
          chk("beat_wstrb", mem_wstrb, exp_q[0].strb);
          if (mem_ready) begin
            void'(exp_q.pop_front());
            beats_seen++;
          end
        end
      end
      if (done) begin
        chk("done_expected", outstanding, 1);
        if (outstanding) begin
          chk("beats_left_at_done", exp_q.size(), 0);
          chk("misaligned_err", misaligned_err, exp_err);
          outstanding = 0;
          done_cyc    = cyc;
          ready_check = 1;
        end
      end else begin
        chk("err_without_done", misaligned_err, 0);
      end
      if (outstanding) chk("req_ready_busy", req_ready, 0);
    end
  end

  task automatic issue(input logic [63:0] a, input logic [63:0] d, input logic [1:0] s,
                       input int stall);
    int k;
    @(posedge clk); #1;
    req_valid = 1'b1;
    req_addr  = a;
    req_data  = d;
    req_size  = s;
    stall_cnt = stall;
    acc_n     = cyc;
    k = 0;
    while (!req_ready && k < 50) begin
      @(posedge clk); #1;
      acc_n = cyc;
      k++;
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
    model(a, d, s);
    exp_q       = m_beats;
    exp_nbeats  = m_beats.size();
    exp_err     = m_err;
    beats_seen  = 0;
    outstanding = 1;
  endtask

  task automatic run_store(input logic [63:0] a, input logic [63:0] d, input logic [1:0] s,
                           input int stall, output int lat, output int nbeats);
    int k;
    issue(a, d, s, stall);
    k = 0;
    while (outstanding && k < 60) begin
      @(negedge clk);
      k++;
    end
    chk("done_timeout", outstanding, 0);
    if (outstanding) begin
      outstanding = 0;
      exp_q.delete();
    end
    lat    = done_cyc - acc_n;
    nbeats = beats_seen;
    chk("beat_count", nbeats, exp_nbeats);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish (compared %0d)", compared);
    $fatal(1, "watchdog");
  end

  initial begin
    int    lat;
    int    nb;
    beat_t b0;
    beat_t b1;
    logic [63:0] ra;
    logic [63:0] rd;
    logic [1:0]  rs;

    rst = 1'b1; req_valid = 1'b0; req_addr = '0; req_data = '0; req_size = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_mem_valid", mem_valid, 0);
    chk("rst_done", done, 0);
    chk("rst_err", misaligned_err, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_mem_wstrb", mem_wstrb, 0);
    chk("rst_req_ready", req_ready, 1);

    // sb 0x1003 0xAB
    model(64'h1003, 64'hAB, 2'd0);
    chk("pin_sb_nbeats", m_beats.size(), 1);
    if (m_beats.size() == 1) begin
      b0 = m_beats[0];
      chk("pin_sb_addr", b0.addr, 64'h1000);
      chk("pin_sb_strb", b0.strb, 8'h08);
      chk("pin_sb_data", b0.data, 64'h00000000AB000000);
    end
    run_store(64'h1003, 64'hFFFF_FFFF_FFFF_FFAB, 2'd0, 0, lat, nb);
    chk("sb_latency", lat, 2);

    // sd 0x2000 with three stall cycles
    model(64'h2000, 64'h1122334455667788, 2'd3);
    if (m_beats.size() == 1) begin
      b0 = m_beats[0];
      chk("pin_sd_strb", b0.strb, 8'hFF);
      chk("pin_sd_data", b0.data, 64'h1122334455667788);
    end
    run_store(64'h2000, 64'h1122334455667788, 2'd3, 3, lat, nb);
    chk("sd_stall_latency", lat, 5);

    // sw 0x3006 crossing
    model(64'h3006, 64'hDEADBEEF, 2'd2);
`ifdef STORE_MISALIGNED_SPLIT_EN
    chk("pin_sw_nbeats", m_beats.size(), 2);
    if (m_beats.size() == 2) begin
      b0 = m_beats[0];
      b1 = m_beats[1];
      chk("pin_sw_b0_addr", b0.addr, 64'h3000);
      chk("pin_sw_b0_strb", b0.strb, 8'hC0);
      chk("pin_sw_b0_data", b0.data[63:48], 16'hBEEF);
      chk("pin_sw_b1_addr", b1.addr, 64'h3008);
      chk("pin_sw_b1_strb", b1.strb, 8'h03);
      chk("pin_sw_b1_data", b1.data[15:0], 16'hDEAD);
    end
    run_store(64'h3006, 64'hDEADBEEF, 2'd2, 0, lat, nb);
    chk("sw_split_latency", lat, 3);
`else
    chk("pin_sw_nbeats", m_beats.size(), 0);
    chk("pin_sw_err", m_err, 1);
    run_store(64'h3006, 64'hDEADBEEF, 2'd2, 0, lat, nb);
    chk("sw_drop_latency", lat, 1);
`endif

    // sd at top of address space
    model(64'hFFFF_FFFF_FFFF_FFFC, 64'h0102030405060708, 2'd3);
`ifdef STORE_MISALIGNED_SPLIT_EN
    if (m_beats.size() == 2) begin
      b0 = m_beats[0];
      b1 = m_beats[1];
      chk("pin_wrap_b0_strb", b0.strb, 8'hF0);
      chk("pin_wrap_b1_addr", b1.addr, 64'h0);
      chk("pin_wrap_b1_strb", b1.strb, 8'h0F);
    end
    run_store(64'hFFFF_FFFF_FFFF_FFFC, 64'h0102030405060708, 2'd3, 0, lat, nb);
    chk("wrap_latency", lat, 3);
`else
    chk("pin_wrap_err", m_err, 1);
    run_store(64'hFFFF_FFFF_FFFF_FFFC, 64'h0102030405060708, 2'd3, 0, lat, nb);
    chk("wrap_drop_latency", lat, 1);
`endif

    // Reset while BEAT0 is stalled
    issue(64'h4000, 64'h55, 2'd0, 1000);
    repeat (3) @(negedge clk);
    chk("stalled_valid", mem_valid, 1);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    exp_q.delete();
    outstanding = 0;
    stall_cnt   = 0;
    @(negedge clk);
    chk("midrst_mem_valid", mem_valid, 0);
    chk("midrst_done", done, 0);
    chk("midrst_req_ready", req_ready, 1);
    repeat (8) @(negedge clk);

    // Randomized stores with random backpressure
    rand_ready = 1;
    for (int t = 0; t < 250; t++) begin
      ra = {$urandom, $urandom};
      if ($urandom_range(0, 7) == 0) ra[63:8] = '1;
      rd = {$urandom, $urandom};
      rs = 2'($urandom_range(0, 3));
      run_store(ra, rd, rs, 0, lat, nb);
      repeat ($urandom_range(0, 2)) @(posedge clk);
    end
    rand_ready = 0;
    repeat (4) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/store_unit.md
STORE_UNIT -- requirements
Module: store_unit

Interface
REQ-001 The module SHALL take parameter DATA_WIDTH, default 64, as the data bus width in bits; only 64 is supported.
REQ-002 The module SHALL take parameter ADDR_WIDTH, default 64, as the byte address width.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 req_valid  input  1  store request present.
REQ-006 req_ready  output  1  unit can accept a request.
REQ-007 req_addr  input  ADDR_WIDTH  byte address of store.
REQ-008 req_data  input  DATA_WIDTH  store data, LSB-justified; bits above size ignored.
REQ-009 req_size  input  2  0=byte, 1=half, 2=word, 3=double.
REQ-010 mem_valid  output  1  write beat valid.
REQ-011 mem_ready  input  1  memory accepts beat.
REQ-012 mem_addr  output  ADDR_WIDTH  8-byte-aligned beat address, bits [2:0] always 0.
REQ-013 mem_wdata  output  DATA_WIDTH  lane-aligned write data.
REQ-014 mem_wstrb  output  8  byte-lane enables.
REQ-015 done  output  1  one-cycle pulse, store complete.
REQ-016 misaligned_err  output  1  one-cycle pulse with done when a crossing store is dropped.

Function
REQ-017 The states SHALL be IDLE, BEAT0, BEAT1 and DONE; req_ready = 1 only in IDLE.
REQ-018 A request SHALL be accepted on req_valid && req_ready; addr, data and size are latched, and the state moves to BEAT0 (or DONE per REQ-024).
REQ-019 Alignment: off = addr[2:0], n = 1<<size; data masked to n bytes and shifted left by 8*off into a 128-bit value; strobe ((1<<n)-1)<<off as a 16-bit value.
REQ-020 BEAT0 SHALL drive mem_valid=1, mem_addr={addr[63:3],3'b0}, wdata/wstrb = low 64/8 bits of the shifted values.
REQ-021 mem_valid and all mem_* outputs SHALL hold stable until mem_ready; no beat is dropped or repeated.
REQ-022 On a BEAT0 handshake: if off+n <= 8, go to DONE; else go to BEAT1.
REQ-023 BEAT1 SHALL drive mem_addr = BEAT0 address + 8 (modulo 2^ADDR_WIDTH, wraps to 0) with the upper 64/8 bits of the shifted data/strobe; on handshake, go to DONE.
REQ-024 DONE SHALL assert done=1 for exactly one cycle with mem_valid=0, then go to IDLE.
REQ-025 Minimum latency: accept at cycle N, BEAT0 valid at N+1; with mem_ready=1, done at N+2 (single beat) or N+3 (split); req_ready again one cycle after done.
REQ-026 mem_wstrb SHALL never be all-zero while mem_valid=1.

Reset
REQ-027 With rst=1 at an edge, state SHALL become IDLE and all registered outputs clear: mem_valid=0, done=0, misaligned_err=0, mem_addr/wdata/wstrb=0; req_ready=1 from the following cycle.
REQ-028 Reset mid-transaction SHALL abandon the store; no further beat or done is issued.

Configuration
REQ-029 Macro STORE_MISALIGNED_SPLIT_EN defined: crossing stores split per REQ-022/023, and misaligned_err is tied to 0.
REQ-030 Macro undefined: a crossing store (off+n > 8) SHALL issue no beat, go directly to DONE, and pulse done and misaligned_err together; BEAT1 is not implemented.

Structure
REQ-031 Enum mem_size_e (BYTE, HALF, WORD, DOUBLE) and typedef strb_t (logic [7:0]) SHALL live in utils_pkg next to the existing extension helpers.
REQ-032 The combinational shift/strobe generation (REQ-019) SHALL be a sub-module store_align; store_unit holds the FSM and registers.

Verification
REQ-033 sb addr 0x1003 data 0xAB, mem_ready=1 -> one beat addr 0x1000, wstrb 0x08, wdata 0x00000000AB000000, done at N+2.
REQ-034 sd addr 0x2000 data 0x1122334455667788, mem_ready low 3 cycles -> outputs stable throughout, wstrb 0xFF, single done.
REQ-035 sw addr 0x3006 data 0xDEADBEEF, split enabled -> beat 0x3000 wstrb 0xC0 wdata[63:48]=0xBEEF; beat 0x3008 wstrb 0x03 wdata[15:0]=0xDEAD; done.
REQ-036 sd addr 0xFFFFFFFFFFFFFFFC, split enabled -> second beat mem_addr 0x0 wstrb 0x0F.
REQ-037 Same stimulus as REQ-035 with macro undefined -> no mem_valid, done and misaligned_err pulse together at N+1.
REQ-038 rst asserted while BEAT0 is stalled -> mem_valid=0 next cycle, no done, req_ready=1 after.
